stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the four-digit MM:SS stopwatch counter datapath.
- Debounces the three front-panel buttons and converts them into single-cycle press events.
- Runs a run/pause/lap/idle state machine.
- Drives the counter datapath with a prescaled count-enable pulse, a clear pulse and a display-freeze (lap) level.
- Sits between the raw board buttons and the counter/seven-segment path; one instance per clock domain.

Parameters:
TICK_DIV, 50000000, clk cycles per count_en pulse (1 s at 50 MHz); legal range ≥2.
DB_CYCLES, 500000, consecutive stable synchronized cycles required to accept a button level change; legal range ≥1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
btn_startstop  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  input  1  raw lap button, active-high, asynchronous
btn_clear  input  1  raw clear button, active-high, asynchronous
count_en  output  1  one-cycle pulse: advance datapath by one count
count_clr  output  1  one-cycle pulse: zero all four digits
lap_hold  output  1  level: datapath keeps counting, display register frozen
running  output  1  level: high in RUN or LAP
state  output  2  current state encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3

Behaviour:
Reset, while asserted:
- state=IDLE; count_en, count_clr, lap_hold and running all 0.
- Prescaler, debounce counters, synchronizers and debounced levels all 0.
- Reset asserted mid-operation aborts everything immediately. No event or pulse is generated on release.

Button path, per button, independently:
- 2-FF synchronizer.
- Debounce counter, width $clog2(DB_CYCLES+1). It counts while the synchronized value differs from the debounced level and clears to 0 when they are equal.
- When the count reaches DB_CYCLES, the debounced level takes the synchronized value and the counter clears.
- A press event is a 1-cycle pulse on a rising debounced level; release generates no event.
- Glitches shorter than DB_CYCLES are ignored.
- Latency from a stable input change to the event pulse is DB_CYCLES+2 cycles.

Event priority when events coincide in one cycle: clear > startstop > lap. Only the highest-priority event acts; the others are discarded.

State transitions (registered; take effect on the edge after the event pulse):
- IDLE: startstop→RUN. clear→IDLE with count_clr pulse. lap ignored.
- RUN: startstop→PAUSE. lap→LAP. clear ignored.
- LAP: lap→RUN (display releases). startstop→PAUSE with lap_hold dropped. clear ignored.
- PAUSE: startstop→RUN. clear→IDLE with count_clr pulse. lap ignored.

Outputs:
- count_clr is registered and high for exactly one cycle, in the cycle state becomes IDLE via clear.
- lap_hold = (state==LAP), registered.
- running = (state==RUN or LAP).

Prescaler:
- Counter width $clog2(TICK_DIV); increments only while running.
- At value TICK_DIV-1 it wraps to 0 and count_en pulses for that single cycle.
- In PAUSE it holds its value, so resume keeps the partial second.
- The clear event zeroes it.
- count_en is never asserted in IDLE or PAUSE.
- Entering RUN from IDLE: the first count_en occurs TICK_DIV cycles after state becomes RUN.
- count_en and count_clr are never high in the same cycle.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
1. Assert reset mid-count with btn_startstop held → all outputs 0 and state=0 immediately. After release, no event until the button is released and pressed again.
2. Press btn_startstop high for 10 cycles from IDLE → state=1, DB_CYCLES+3=6 edges after the press. count_en pulses every 4th cycle, first 4 cycles after RUN entry.
3. In RUN, toggle btn_lap high for 2 cycles (glitch) → no change. Then hold it 8 cycles → state=3, lap_hold=1, count_en continues every 4 cycles. Second lap press → state=1, lap_hold=0.
4. RUN with prescaler at 2, then startstop → PAUSE, state=2, no count_en for 40 cycles. Then startstop → RUN, first count_en after 2 cycles (value resumes at 2).
5. PAUSE: press clear and startstop, rising together → state=0, count_clr=1 for exactly 1 cycle, prescaler=0. Then clear in IDLE → another single count_clr pulse, state stays 0.
6. RUN: press clear alone → ignored (state=1, no count_clr). Press lap and startstop together → state=2, lap_hold=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: front-panel control sequencer for the MM:SS stopwatch.
// Debounces three raw buttons into press events, runs the IDLE/RUN/PAUSE/LAP
// state machine and drives the counter datapath with a prescaled count_en
// pulse, a count_clr pulse and a lap_hold display-freeze level.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(TICK_DIV);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  // Bit order of the button vectors: 0 = startstop, 1 = lap, 2 = clear.
  logic [2:0] btn_raw;
  logic [2:0] btn_event;
  assign btn_raw = {btn_clear, btn_lap, btn_startstop};

  // The synchronizers need two edges after reset before they show the real
  // pad level; buttons are only armed once they have been seen released, so a
  // button held through reset never produces a press event on release of reset.
  logic [1:0] settle_reg;
  logic       settle_done;
  assign settle_done = (settle_reg == 2'd2);

  // Count the first two cycles after reset so arming waits for valid sync data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      settle_reg <= 2'd0;
    else if (!settle_done)
      settle_reg <= settle_reg + 2'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic           meta_reg;
      logic           sync_reg;
      logic           level_reg;
      logic           arm_reg;
      logic           event_reg;
      logic [DBW-1:0] cnt_reg;

      // Synchronize, debounce and emit a one-cycle event on an accepted rising level.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_reg  <= 1'b0;
          sync_reg  <= 1'b0;
          level_reg <= 1'b0;
          arm_reg   <= 1'b0;
          event_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          meta_reg  <= btn_raw[gi];
          sync_reg  <= meta_reg;
          event_reg <= 1'b0;
          if (settle_done && !sync_reg && !level_reg)
            arm_reg <= 1'b1;
          if (sync_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            // DB_CYCLES consecutive differing samples: accept the new level.
            level_reg <= sync_reg;
            cnt_reg   <= '0;
            event_reg <= sync_reg & arm_reg;
          end else begin
            cnt_reg <= cnt_reg + DBW'(1);
          end
        end
      end

      assign btn_event[gi] = event_reg;
    end
  endgenerate

  // Priority resolution: clear beats startstop beats lap; losers are dropped.
  logic act_clr, act_ss, act_lap;
  assign act_clr = btn_event[2];
  assign act_ss  = btn_event[0] & ~btn_event[2];
  assign act_lap = btn_event[1] & ~btn_event[0] & ~btn_event[2];

  logic [1:0]    state_reg, state_next;
  logic          clr_next;
  logic          running_reg, running_next;
  logic          lap_hold_reg, count_clr_reg, count_en_reg;
  logic [PW-1:0] pre_reg;
  logic          advance;

  // Next-state decode; count_clr is requested only on a clear that lands in IDLE.
  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (act_ss)       state_next = S_RUN;
        else if (act_clr) clr_next   = 1'b1;
      end
      S_RUN: begin
        if (act_ss)       state_next = S_PAUSE;
        else if (act_lap) state_next = S_LAP;
      end
      S_LAP: begin
        if (act_lap)      state_next = S_RUN;
        else if (act_ss)  state_next = S_PAUSE;
      end
      default: begin
        if (act_ss) begin
          state_next = S_RUN;
        end else if (act_clr) begin
          state_next = S_IDLE;
          clr_next   = 1'b1;
        end
      end
    endcase
  end

  assign running_next = (state_next == S_RUN) || (state_next == S_LAP);
  // The prescaler only moves on edges where counting continues, so the edge
  // that enters PAUSE freezes the partial second and the entry edge into RUN
  // starts a full TICK_DIV period.
  assign advance = running_reg && running_next;

  // State register and registered level/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      running_reg   <= 1'b0;
      lap_hold_reg  <= 1'b0;
      count_clr_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      running_reg   <= running_next;
      lap_hold_reg  <= (state_next == S_LAP);
      count_clr_reg <= clr_next;
    end
  end

  // Prescaler: wraps at TICK_DIV-1 with a single count_en pulse; cleared by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg      <= '0;
      count_en_reg <= 1'b0;
    end else begin
      count_en_reg <= 1'b0;
      if (clr_next) begin
        pre_reg <= '0;
      end else if (advance) begin
        if (pre_reg == PRE_LAST) begin
          pre_reg      <= '0;
          count_en_reg <= 1'b1;
        end else begin
          pre_reg <= pre_reg + PW'(1);
        end
      end
    end
  end

  assign count_en  = count_en_reg;
  assign count_clr = count_clr_reg;
  assign lap_hold  = lap_hold_reg;
  assign running   = running_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenario bench for stopwatch_ctrl with
// TICK_DIV=4 and DB_CYCLES=3. Button edges are driven on the falling clock
// edge and outputs are sampled on the falling edge. Variable c counts falling
// edges since RUN entry so that, while counting continuously, count_en is
// expected high exactly when c is a nonzero multiple of 4.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_startstop;
  logic       btn_lap;
  logic       btn_clear;
  logic       count_en;
  logic       count_clr;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int c        = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_startstop(btn_startstop),
    .btn_lap      (btn_lap),
    .btn_clear    (btn_clear),
    .count_en     (count_en),
    .count_clr    (count_clr),
    .lap_hold     (lap_hold),
    .running      (running),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_startstop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    step(3);
    n_checks++;
    if ({state, count_en, count_clr, lap_hold, running} !== 6'b0) begin
      $display("FAIL reset_init: outputs=%b expected 000000", {state, count_en, count_clr, lap_hold, running});
      n_fail++;
    end
    reset = 1'b0;
    step(4);
    btn_startstop = 1'b1;
    step(6);
    n_checks++;
    if (state !== 2'd1) begin
      $display("FAIL reset_setup_run: state=%0d expected 1", state);
      n_fail++;
    end
    btn_startstop = 1'b0;
    step(8);
    // Hold startstop, then hit reset asynchronously between clock edges.
    btn_startstop = 1'b1;
    step(2);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({state, count_en, count_clr, lap_hold, running} !== 6'b0) begin
      $display("FAIL reset_async: outputs=%b expected 000000", {state, count_en, count_clr, lap_hold, running});
      n_fail++;
    end
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++;
      if ({state, count_en, count_clr} !== 4'b0) begin
        $display("FAIL reset_held_btn cyc %0d: state=%0d en=%b clr=%b expected 0 0 0", i, state, count_en, count_clr);
        n_fail++;
      end
    end
    btn_startstop = 1'b0;
    step(10);
    btn_startstop = 1'b1;
    step(5);
    n_checks++;
    if (state !== 2'd0) begin
      $display("FAIL reset_repress_early: state=%0d expected 0", state);
      n_fail++;
    end
    step(1);
    n_checks++;
    if (state !== 2'd1) begin
      $display("FAIL reset_repress: state=%0d expected 1", state);
      n_fail++;
    end
    btn_startstop = 1'b0;
    step(8);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_startstop_run();
    btn_startstop = 1'b1;
    step(5);
    n_checks++;
    if (state !== 2'd0) begin
      $display("FAIL run_latency_early: state=%0d expected 0", state);
      n_fail++;
    end
    step(1);
    n_checks++;
    if (state !== 2'd1 || running !== 1'b1) begin
      $display("FAIL run_entry: state=%0d running=%b expected 1 1", state, running);
      n_fail++;
    end
    c = 0;
    for (int i = 0; i < 12; i++) begin
      if (c == 4) btn_startstop = 1'b0;
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL run_count_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    $display("test_startstop_run done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_lap();
    btn_lap = 1'b1;
    step(2);
    btn_lap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++;
      if (state !== 2'd1 || lap_hold !== 1'b0 || count_en !== (c % 4 == 0)) begin
        $display("FAIL lap_glitch c=%0d: state=%0d lap_hold=%b en=%b expected 1 0 %b", c, state, lap_hold, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    btn_lap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL lap_press_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    n_checks++;
    if (state !== 2'd3 || lap_hold !== 1'b1 || running !== 1'b1) begin
      $display("FAIL lap_enter: state=%0d lap_hold=%b running=%b expected 3 1 1", state, lap_hold, running);
      n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 2) btn_lap = 1'b0;
      step(1);
      n_checks++;
      if (state !== 2'd3 || count_en !== (c % 4 == 0)) begin
        $display("FAIL lap_counting c=%0d: state=%0d en=%b expected 3 %b", c, state, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    btn_lap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL lap_release_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    n_checks++;
    if (state !== 2'd1 || lap_hold !== 1'b0) begin
      $display("FAIL lap_exit: state=%0d lap_hold=%b expected 1 0", state, lap_hold);
      n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 2) btn_lap = 1'b0;
      step(1);
    end
    $display("test_lap done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_pause();
    // Press so the event cycle sees prescaler value 2 (c = 1 mod 4 at press).
    while (c % 4 != 1) step(1);
    btn_startstop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL pause_press_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 4) btn_startstop = 1'b0;
      n_checks++;
      if (state !== 2'd2 || running !== 1'b0 || count_en !== 1'b0) begin
        $display("FAIL pause_hold cyc %0d: state=%0d running=%b en=%b expected 2 0 0", i, state, running, count_en);
        n_fail++;
      end
      step(1);
    end
    btn_startstop = 1'b1;
    step(6);
    n_checks++;
    if (state !== 2'd1) begin
      $display("FAIL pause_resume: state=%0d expected 1", state);
      n_fail++;
    end
    c = 2;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) btn_startstop = 1'b0;
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL resume_count_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    $display("test_pause done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_clear();
    while (c % 4 != 1) step(1);
    btn_startstop = 1'b1;
    step(6);
    n_checks++;
    if (state !== 2'd2) begin
      $display("FAIL clear_setup_pause: state=%0d expected 2", state);
      n_fail++;
    end
    btn_startstop = 1'b0;
    step(10);
    btn_clear = 1'b1;
    btn_startstop = 1'b1;
    step(5);
    n_checks++;
    if (state !== 2'd2 || count_clr !== 1'b0) begin
      $display("FAIL clear_early: state=%0d count_clr=%b expected 2 0", state, count_clr);
      n_fail++;
    end
    step(1);
    n_checks++;
    if (state !== 2'd0 || count_clr !== 1'b1 || running !== 1'b0 || count_en !== 1'b0) begin
      $display("FAIL clear_pause: state=%0d clr=%b running=%b en=%b expected 0 1 0 0", state, count_clr, running, count_en);
      n_fail++;
    end
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        btn_clear = 1'b0;
        btn_startstop = 1'b0;
      end
      step(1);
      n_checks++;
      if (state !== 2'd0 || count_clr !== 1'b0) begin
        $display("FAIL clear_after cyc %0d: state=%0d count_clr=%b expected 0 0", i, state, count_clr);
        n_fail++;
      end
    end
    btn_clear = 1'b1;
    step(6);
    n_checks++;
    if (state !== 2'd0 || count_clr !== 1'b1) begin
      $display("FAIL clear_idle: state=%0d count_clr=%b expected 0 1", state, count_clr);
      n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 3) btn_clear = 1'b0;
      step(1);
      n_checks++;
      if (state !== 2'd0 || count_clr !== 1'b0) begin
        $display("FAIL clear_idle_after cyc %0d: state=%0d count_clr=%b expected 0 0", i, state, count_clr);
        n_fail++;
      end
    end
    $display("test_clear done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_back_to_back();
    btn_startstop = 1'b1;
    step(6);
    n_checks++;
    if (state !== 2'd1) begin
      $display("FAIL b2b_run: state=%0d expected 1", state);
      n_fail++;
    end
    c = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) btn_startstop = 1'b0;
      step(1);
      n_checks++;
      if (count_en !== (c % 4 == 0)) begin
        $display("FAIL b2b_count_en c=%0d: count_en=%b expected %b", c, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    btn_clear = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) btn_clear = 1'b0;
      step(1);
      n_checks++;
      if (state !== 2'd1 || count_clr !== 1'b0 || count_en !== (c % 4 == 0)) begin
        $display("FAIL run_clear_ignored c=%0d: state=%0d clr=%b en=%b expected 1 0 %b", c, state, count_clr, count_en, (c % 4 == 0));
        n_fail++;
      end
    end
    btn_lap = 1'b1;
    btn_startstop = 1'b1;
    step(5);
    step(1);
    n_checks++;
    if (state !== 2'd2 || lap_hold !== 1'b0 || running !== 1'b0 || count_en !== 1'b0) begin
      $display("FAIL lap_ss_together: state=%0d lap_hold=%b running=%b en=%b expected 2 0 0 0", state, lap_hold, running, count_en);
      n_fail++;
    end
    btn_lap = 1'b0;
    btn_startstop = 1'b0;
    step(10);
    n_checks++;
    if (state !== 2'd2) begin
      $display("FAIL lap_ss_settle: state=%0d expected 2", state);
      n_fail++;
    end
    $display("test_back_to_back done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    test_reset();
    test_startstop_run();
    test_lap();
    test_pause();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
